// File: rtl/addsub_rr_sched.sv
// Round-robin scheduler sharing one signed add/sub unit between two requesters.
// Build option ADDSUB_SAT_EN: saturate res_sum on signed overflow (flags still raw).
module addsub_rr_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_id
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             id;
  } op_t;

  state_t           state, state_nxt;
  op_t              op;
  logic             last_grant;
  logic             gnt_vld, gnt, take;
  logic [WIDTH-1:0] b_eff, sum, sum_out;
  logic [WIDTH:0]   full;
  logic             ovf;

  // Tie goes to whoever did not win last; a lone requester always wins.
  assign gnt_vld    = req0_valid | req1_valid;
  assign gnt        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = !rst && (state == IDLE) && gnt_vld && !gnt;
  assign req1_ready = !rst && (state == IDLE) && gnt_vld &&  gnt;
  assign take       = req0_ready | req1_ready;

  assign b_eff = op.sub ? ~op.b : op.b;
  assign full  = {1'b0, op.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op.sub};
  assign sum   = full[WIDTH-1:0];
  assign ovf   = (op.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op.a[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
  always_comb begin
    sum_out = sum;
    if (ovf) sum_out = op.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign sum_out = sum;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      op         <= '0;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_ovf    <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      if (take) begin
        op.a       <= gnt ? req1_a   : req0_a;
        op.b       <= gnt ? req1_b   : req0_b;
        op.sub     <= gnt ? req1_sub : req0_sub;
        op.id      <= gnt;
        last_grant <= gnt;
      end
      if (state == EXEC) begin
        res_sum   <= sum_out;
        res_cout  <= full[WIDTH];
        res_ovf   <= ovf;
        res_id    <= op.id;
        res_valid <= 1'b1;
      end
      // Result fields stay put after the handshake; only the valid drops.
      if (state == DONE && res_ready) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_rr_sched.sv
// Scoreboard bench for addsub_rr_sched: directed vectors, monitor pops on result handshake.
module tb_addsub_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_sub;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [15:0] req1_a, req1_b;
  logic        res_valid, res_ready, res_cout, res_ovf, res_id;
  logic [15:0] res_sum;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        id;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  addsub_rr_sched #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_ovf(res_ovf), .res_id(res_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every result handshake; also watch for dual grants.
  always @(negedge clk) begin
    if (req0_ready || req1_ready) chk("one_ready", {30'd0, req1_ready, req0_ready} & {30'd0, req1_ready & req0_ready, 1'b1}, {30'd0, 1'b0, req0_ready});
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result actual=%h expected=none", {res_sum, res_cout, res_ovf, res_id});
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("res_sum",  {16'd0, res_sum},  {16'd0, e.sum});
        chk("res_cout", {31'd0, res_cout}, {31'd0, e.cout});
        chk("res_ovf",  {31'd0, res_ovf},  {31'd0, e.ovf});
        chk("res_id",   {31'd0, res_id},   {31'd0, e.id});
      end
    end
  end

  task automatic push(input logic [15:0] s, input logic c, input logic o, input logic id);
    sb.push_back({s, c, o, id});
  endtask

  task automatic set_req(input logic id, input logic [15:0] a, input logic [15:0] b, input logic sub);
    if (id) begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1; end
  endtask

  task automatic wait_ready(input logic id);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL ready_timeout actual=0 expected=1 id=%0d", id); end
  endtask

  task automatic wait_res_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL res_valid_timeout actual=0 expected=1"); end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin checks++; errors++; $display("FAIL drain_timeout actual=%0d expected=0", sb.size()); end
    @(posedge clk); #1;
  endtask

  // One lone request with res_ready high; expected result goes into the scoreboard.
  task automatic single(input logic id, input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [15:0] es, input logic ec, input logic eo);
    set_req(id, a, b, sub);
    wait_ready(id);
    push(es, ec, eo, id);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int last_cyc;
    rst = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0; req0_b = 16'h0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = 16'h0; req1_b = 16'h0; req1_sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_sum",   {16'd0, res_sum},   32'd0);
    chk("rst_res_flags", {29'd0, res_cout, res_ovf, res_id}, 32'd0);
    chk("rst_ready",     {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0;

    // First add with explicit latency checks
    set_req(1'b0, 16'h0003, 16'h0004, 1'b0);
    wait_ready(1'b0);
    push(16'h0007, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1; req0_valid = 1'b0;
    @(negedge clk);
    chk("lat_t1_valid", {31'd0, res_valid}, 32'd0);
    chk("lat_t1_ready", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    chk("lat_t2_valid", {31'd0, res_valid}, 32'd1);
    drain();

    single(1'b1, 16'h0002, 16'h0005, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    single(1'b1, 16'h0005, 16'h0002, 1'b1, 16'h0003, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
    single(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    single(1'b0, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
    single(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    single(1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Round-robin: fresh reset so requester 0 takes the first tie
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    set_req(1'b0, 16'h0010, 16'h0001, 1'b0);
    set_req(1'b1, 16'h0020, 16'h0002, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push(16'h0011, 1'b0, 1'b0, 1'b0);
      else            push(16'h001E, 1'b1, 1'b0, 1'b1);
    end
    last_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      bit ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin checks++; errors++; $display("FAIL rr_timeout actual=0 expected=1 k=%0d", k); end
      chk("rr_id", {31'd0, req1_ready}, k % 2);
      if (k > 0) chk("rr_spacing", cyc - last_cyc, 32'd3);
      last_cyc = cyc;
    end
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Backpressure: result held 5 cycles while requester 1 waits
    res_ready = 1'b0;
    set_req(1'b0, 16'h0001, 16'h0002, 1'b0);
    wait_ready(1'b0);
    push(16'h0003, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    set_req(1'b1, 16'h0005, 16'h0005, 1'b1);
    wait_res_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_sum",   {16'd0, res_sum},   32'h0003);
      chk("bp_flags", {29'd0, res_cout, res_ovf, res_id}, 32'd0);
      chk("bp_no_ready", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1; res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid_drop", {31'd0, res_valid}, 32'd0);
    chk("bp_next_grant", {31'd0, req1_ready}, 32'd1);
    push(16'h0000, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1; req1_valid = 1'b0;
    drain();

    // Reset while in EXEC, with a tie pending
    res_ready = 1'b0;
    set_req(1'b0, 16'h1111, 16'h1111, 1'b0);
    wait_ready(1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(1'b1, 16'h0040, 16'h0001, 1'b0);
    @(negedge clk);
    chk("rexec_ready_in_rst", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rexec_valid", {31'd0, res_valid}, 32'd0);
    chk("rexec_res",   {13'd0, res_sum, res_cout, res_ovf, res_id}, 32'd0);
    chk("rexec_tie",   {30'd0, req1_ready, req0_ready}, 32'd1);
    push(16'h2222, 1'b0, 1'b0, 1'b0);
    res_ready = 1'b1;
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Reset while in DONE (last grant was 0, so a tie afterwards shows the reset grant state)
    res_ready = 1'b0;
    set_req(1'b0, 16'hF000, 16'h1001, 1'b0);
    wait_ready(1'b0);
    @(posedge clk); #1; req0_valid = 1'b0;
    wait_res_valid();
    chk("rdone_pre_sum",  {16'd0, res_sum},  32'h0001);
    chk("rdone_pre_cout", {31'd0, res_cout}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(1'b0, 16'h0008, 16'h0003, 1'b1);
    set_req(1'b1, 16'h0040, 16'h0001, 1'b0);
    @(negedge clk);
    chk("rdone_ready_in_rst", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rdone_valid", {31'd0, res_valid}, 32'd0);
    chk("rdone_res",   {13'd0, res_sum, res_cout, res_ovf, res_id}, 32'd0);
    chk("rdone_tie",   {30'd0, req1_ready, req0_ready}, 32'd1);
    push(16'h0005, 1'b1, 1'b0, 1'b0);
    res_ready = 1'b1;
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
